// File: rtl/filter_tb_harness_if.sv
// Sample/result stream between the harness and the filter under test.
// The master side drives vOut/dOut and receives the filter result on vIn/dIn.
interface filter_tb_harness_if #(
  parameter int NB = 12
);
  logic          vOut;
  logic [NB-1:0] dOut;
  logic          vIn;
  logic [NB-1:0] dIn;

  modport master (
    output vOut,
    output dOut,
    input  vIn,
    input  dIn
  );

  modport slave (
    input  vOut,
    input  dOut,
    output vIn,
    output dIn
  );
endinterface

// File: rtl/filter_tb_harness.sv
// Stimulus source and result sink for the biquad filter: emits a ramp with optional gaps,
// raises a sticky end_sim after a drain period, and counts/checksums the filter outputs.
module filter_tb_harness #(
  parameter int NB        = 12,
  parameter int N_SAMPLES = 200,
  parameter int START     = 0,
  parameter int STEP      = 1,
  parameter int GAP       = 0,
  parameter int DRAIN     = 20,
  parameter int B0        = 421,
  parameter int B1        = 842,
  parameter int B2        = 421,
  parameter int A1        = -1180,
  parameter int A2        = 440
) (
  input  logic                clock,
  input  logic                reset_n,
  filter_tb_harness_if.master bus,
  output logic [3*NB-1:0]     b,
  output logic [2*NB-1:0]     a,
  output logic                end_sim,
  output logic [15:0]         rx_count,
  output logic [31:0]         rx_sum,
  output logic [NB-1:0]       rx_last
);

  localparam int IDX_W = $clog2(N_SAMPLES + 1) + 1;
  localparam int GAP_W = $clog2(GAP + 1) + 1;
  localparam int DRN_W = $clog2(DRAIN + 1) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [DRN_W-1:0] DRN_END  = DRN_W'(DRAIN);
  localparam logic [NB-1:0]    START_V  = NB'(START);
  localparam logic [NB-1:0]    STEP_V   = NB'(STEP);

  typedef enum logic [1:0] {
    S_EMIT,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [DRN_W-1:0] drain_reg, drain_next;
  logic [NB-1:0]    smp_reg, smp_next;
  logic             v_reg, v_next;
  logic [NB-1:0]    d_reg, d_next;
  logic             end_reg, end_next;

  logic [15:0]      rx_count_reg, rx_count_next;
  logic [31:0]      rx_sum_reg, rx_sum_next;
  logic [NB-1:0]    rx_last_reg, rx_last_next;

  // Coefficients are fixed wiring; reset has no effect on them.
  assign b = {NB'(B2), NB'(B1), NB'(B0)};
  assign a = {NB'(A2), NB'(A1)};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= S_EMIT;
      idx_reg      <= '0;
      gap_reg      <= '0;
      drain_reg    <= '0;
      smp_reg      <= START_V;
      v_reg        <= 1'b0;
      d_reg        <= '0;
      end_reg      <= 1'b0;
      rx_count_reg <= '0;
      rx_sum_reg   <= '0;
      rx_last_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      gap_reg      <= gap_next;
      drain_reg    <= drain_next;
      smp_reg      <= smp_next;
      v_reg        <= v_next;
      d_reg        <= d_next;
      end_reg      <= end_next;
      rx_count_reg <= rx_count_next;
      rx_sum_reg   <= rx_sum_next;
      rx_last_reg  <= rx_last_next;
    end
  end

  // smp_reg always holds the next sample to issue, so no multiplier is needed.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    gap_next   = gap_reg;
    drain_next = drain_reg;
    smp_next   = smp_reg;
    v_next     = 1'b0;
    d_next     = d_reg;
    end_next   = end_reg;
    case (state_reg)
      S_EMIT: begin
        v_next   = 1'b1;
        d_next   = smp_reg;
        smp_next = smp_reg + STEP_V;
        idx_next = idx_reg + IDX_W'(1);
        gap_next = '0;
        if (idx_reg == LAST_IDX) begin
          state_next = S_DRAIN;
          drain_next = '0;
        end else if (GAP > 0) begin
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        gap_next = gap_reg + GAP_W'(1);
        if (gap_reg == GAP_LAST) begin
          state_next = S_EMIT;
        end
      end
      // The edge that drops vOut is drain count 0; end_sim lands DRAIN edges later.
      S_DRAIN: begin
        if (drain_reg == DRN_END) begin
          end_next   = 1'b1;
          state_next = S_DONE;
        end else begin
          drain_next = drain_reg + DRN_W'(1);
        end
      end
      S_DONE: begin
        end_next = 1'b1;
      end
      default: begin
        state_next = S_EMIT;
      end
    endcase
  end

  always_comb begin
    rx_count_next = rx_count_reg;
    rx_sum_next   = rx_sum_reg;
    rx_last_next  = rx_last_reg;
    if (bus.vIn) begin
      if (rx_count_reg != 16'hFFFF) begin
        rx_count_next = rx_count_reg + 16'd1;
      end
      rx_sum_next  = rx_sum_reg + {{(32 - NB){bus.dIn[NB-1]}}, bus.dIn};
      rx_last_next = bus.dIn;
    end
  end

  assign bus.vOut = v_reg;
  assign bus.dOut = d_reg;
  assign end_sim  = end_reg;
  assign rx_count = rx_count_reg;
  assign rx_sum   = rx_sum_reg;
  assign rx_last  = rx_last_reg;

endmodule

// File: tb/tb_filter_tb_harness.sv
// Bench for filter_tb_harness: three configurations (plain/loopback, gapped, wrap/sign)
// checked against a per-instance scoreboard of expected samples and sink totals.
module tb_filter_tb_harness;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic loop = 1'b0;
  logic mon_en = 1'b0;
  int   cyc = -1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset_n ? cyc + 1 : -1;

  filter_tb_harness_if #(.NB(12)) bus_a ();
  filter_tb_harness_if #(.NB(12)) bus_b ();
  filter_tb_harness_if #(.NB(12)) bus_c ();

  // A and C loop their samples back; B feeds a constant so its sink holds after reset.
  assign bus_a.vIn = loop ? bus_a.vOut : 1'b1;
  assign bus_a.dIn = loop ? bus_a.dOut : 12'd5;
  assign bus_b.vIn = loop ? 1'b0 : 1'b1;
  assign bus_b.dIn = loop ? 12'd7 : 12'd5;
  assign bus_c.vIn = loop ? bus_c.vOut : 1'b1;
  assign bus_c.dIn = loop ? bus_c.dOut : 12'd5;

  logic [35:0] b_a, b_b, b_c;
  logic [23:0] a_a, a_b, a_c;
  logic        end_a, end_b, end_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [31:0] sum_a, sum_b, sum_c;
  logic [11:0] last_a, last_b, last_c;

  filter_tb_harness #(.NB(12), .N_SAMPLES(4), .START(0), .STEP(1), .GAP(0), .DRAIN(3)) u_a (
    .clock(clk), .reset_n(reset_n), .bus(bus_a), .b(b_a), .a(a_a), .end_sim(end_a),
    .rx_count(cnt_a), .rx_sum(sum_a), .rx_last(last_a)
  );
  filter_tb_harness #(.NB(12), .N_SAMPLES(3), .START(0), .STEP(1), .GAP(2), .DRAIN(2)) u_b (
    .clock(clk), .reset_n(reset_n), .bus(bus_b), .b(b_b), .a(a_b), .end_sim(end_b),
    .rx_count(cnt_b), .rx_sum(sum_b), .rx_last(last_b)
  );
  filter_tb_harness #(.NB(12), .N_SAMPLES(2), .START(2047), .STEP(1), .GAP(0), .DRAIN(2)) u_c (
    .clock(clk), .reset_n(reset_n), .bus(bus_c), .b(b_c), .a(a_c), .end_sim(end_c),
    .rx_count(cnt_c), .rx_sum(sum_c), .rx_last(last_c)
  );

  logic        obs_v[3];
  logic [11:0] obs_d[3];
  logic        obs_end[3];
  logic [15:0] obs_cnt[3];
  logic [31:0] obs_sum[3];
  logic [11:0] obs_last[3];

  assign obs_v[0] = bus_a.vOut;  assign obs_v[1] = bus_b.vOut;  assign obs_v[2] = bus_c.vOut;
  assign obs_d[0] = bus_a.dOut;  assign obs_d[1] = bus_b.dOut;  assign obs_d[2] = bus_c.dOut;
  assign obs_end[0] = end_a;     assign obs_end[1] = end_b;     assign obs_end[2] = end_c;
  assign obs_cnt[0] = cnt_a;     assign obs_cnt[1] = cnt_b;     assign obs_cnt[2] = cnt_c;
  assign obs_sum[0] = sum_a;     assign obs_sum[1] = sum_b;     assign obs_sum[2] = sum_c;
  assign obs_last[0] = last_a;   assign obs_last[1] = last_b;   assign obs_last[2] = last_c;

  // Per-instance configuration mirrored from the parameter overrides above.
  int p_n[3]     = '{4, 3, 2};
  int p_gap[3]   = '{0, 2, 0};
  int p_start[3] = '{0, 0, 2047};
  int p_drain[3] = '{3, 2, 2};

  // Expected sink totals once the run has drained.
  int          e_cnt[3]  = '{4, 0, 2};
  logic [31:0] e_sum[3]  = '{32'd6, 32'd0, 32'hFFFF_FFFF};
  logic [11:0] e_last[3] = '{12'd3, 12'd0, 12'h800};

  typedef struct {
    int          cyc;
    logic [11:0] d;
  } exp_t;

  exp_t        sb_q[3][$];
  logic [11:0] hold_d[3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int end_edge(input int i);
    return (p_n[i] - 1) * (p_gap[i] + 1) + 1 + p_drain[i];
  endfunction

  task automatic start_run();
    for (int i = 0; i < 3; i++) begin
      sb_q[i].delete();
      hold_d[i] = 12'd0;
      for (int k = 0; k < p_n[i]; k++) begin
        exp_t e;
        e.cyc = k * (p_gap[i] + 1);
        e.d   = 12'(p_start[i] + k);
        sb_q[i].push_back(e);
      end
    end
    loop    = 1'b1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic check_reset(input string ph);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_i%0d_vout", ph, i), 64'(obs_v[i]), 64'd0);
      check($sformatf("%s_i%0d_dout", ph, i), 64'(obs_d[i]), 64'd0);
      check($sformatf("%s_i%0d_end", ph, i), 64'(obs_end[i]), 64'd0);
      check($sformatf("%s_i%0d_rxcnt", ph, i), 64'(obs_cnt[i]), 64'd0);
      check($sformatf("%s_i%0d_rxsum", ph, i), 64'(obs_sum[i]), 64'd0);
      check($sformatf("%s_i%0d_rxlast", ph, i), 64'(obs_last[i]), 64'd0);
    end
  endtask

  task automatic check_sink(input string ph);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_i%0d_rxcnt", ph, i), 64'(obs_cnt[i]), 64'(e_cnt[i]));
      check($sformatf("%s_i%0d_rxsum", ph, i), 64'(obs_sum[i]), 64'(e_sum[i]));
      check($sformatf("%s_i%0d_rxlast", ph, i), 64'(obs_last[i]), 64'(e_last[i]));
      check($sformatf("%s_i%0d_sb_empty", ph, i), 64'(sb_q[i].size()), 64'd0);
    end
  endtask

  // Scoreboard monitor: one expected sample per strobe, dOut held in between.
  always @(negedge clk) begin
    if (mon_en && cyc >= 0) begin
      for (int i = 0; i < 3; i++) begin
        logic exp_v;
        exp_v = (sb_q[i].size() > 0) && (sb_q[i][0].cyc == cyc);
        check($sformatf("i%0d_vout_c%0d", i, cyc), 64'(obs_v[i]), 64'(exp_v));
        if (obs_v[i] && exp_v) begin
          exp_t e;
          e = sb_q[i].pop_front();
          $display("inst %0d cyc %0d sample %03h", i, cyc, obs_d[i]);
          check($sformatf("i%0d_dout_c%0d", i, cyc), 64'(obs_d[i]), 64'(e.d));
          hold_d[i] = e.d;
        end else if (!obs_v[i]) begin
          check($sformatf("i%0d_hold_c%0d", i, cyc), 64'(obs_d[i]), 64'(hold_d[i]));
        end
        check($sformatf("i%0d_end_c%0d", i, cyc), 64'(obs_end[i]), 64'(cyc >= end_edge(i)));
      end
    end
  end

  initial begin
    // Reset hold with an active sink input that must be ignored.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset("rst_hold");
    check("coef_b", 64'(b_a), 64'({12'd421, 12'd842, 12'd421}));
    check("coef_a", 64'(a_a), 64'({12'd440, 12'hB64}));
    check("coef_b_gap", 64'(b_b), 64'({12'd421, 12'd842, 12'd421}));

    // Full run from release through drain.
    start_run();
    repeat (15) @(negedge clk);
    check_sink("run1");

    // Restart, then reset at e2.
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    start_run();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");

    // After release the stream starts again from sample 0.
    start_run();
    repeat (15) @(negedge clk);
    check_sink("run2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
